// File: rtl/reg_writeback_pkg.sv
// Shared types for the writeback stage: FSM states and load opcodes.
// Imported by the stage and its load alignment helper.
package reg_writeback_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_e;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LH  = 3'd1,
    LD_LW  = 3'd2,
    LD_LBU = 3'd4,
    LD_LHU = 3'd5,
    LD_LWL = 3'd6,
    LD_LWR = 3'd7
  } ld_op_e;

  function automatic logic [WORD-1:0] sext8(input logic [7:0] b);
    return {{(WORD-8){b[7]}}, b};
  endfunction

  function automatic logic [WORD-1:0] sext16(input logic [15:0] h);
    return {{(WORD-16){h[15]}}, h};
  endfunction

endpackage

// File: rtl/reg_writeback_load_align.sv
// Little-endian load data alignment and extension.
// Purely combinational; unknown opcodes pass the word through.
module load_align
  import reg_writeback_pkg::*;
(
  input  logic [WORD-1:0] mem_rdata,
  input  logic [2:0]      ld_op,
  input  logic [1:0]      byte_off,
  input  logic [WORD-1:0] rt_old,
  output logic [WORD-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = mem_rdata[{byte_off, 3'b000} +: 8];
    h = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    data = mem_rdata;
    case (ld_op)
      LD_LB:  data = sext8(b);
      LD_LBU: data = {24'd0, b};
      LD_LH:  data = sext16(h);
      LD_LHU: data = {16'd0, h};
      LD_LWL: begin
        unique case (byte_off)
          2'd0:    data = {mem_rdata[7:0], rt_old[23:0]};
          2'd1:    data = {mem_rdata[15:0], rt_old[15:0]};
          2'd2:    data = {mem_rdata[23:0], rt_old[7:0]};
          default: data = mem_rdata;
        endcase
      end
      LD_LWR: begin
        unique case (byte_off)
          2'd0:    data = mem_rdata;
          2'd1:    data = {rt_old[31:24], mem_rdata[31:8]};
          2'd2:    data = {rt_old[31:16], mem_rdata[31:16]};
          default: data = {rt_old[31:8], mem_rdata[31:24]};
        endcase
      end
      default: data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage driving the register-file write port.
// ALU results retire next cycle; loads wait for memory data first.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_load,
  input  logic [ADDR_WIDTH-1:0] req_rd,
  input  logic [DATA_WIDTH-1:0] req_alu_result,
  input  logic [2:0]            req_ld_op,
  input  logic [1:0]            req_byte_off,
  input  logic [DATA_WIDTH-1:0] req_rt_old,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rdata_valid,
  output logic                  mem_rdata_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  wb_done,
  output logic [CNT_WIDTH-1:0]  wb_count
);

  wb_state_e state, state_nxt;

  logic accept;
  logic mem_hs;

  logic [ADDR_WIDTH-1:0] cap_rd;
  logic [2:0]            cap_op;
  logic [1:0]            cap_off;
  logic [DATA_WIDTH-1:0] cap_rt;
  logic [DATA_WIDTH-1:0] ld_data;

  load_align u_align (
    .mem_rdata (mem_rdata),
    .ld_op     (cap_op),
    .byte_off  (cap_off),
    .rt_old    (cap_rt),
    .data      (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, WRITE: begin
        if (accept) state_nxt = req_is_load ? WAIT_MEM : WRITE;
        else        state_nxt = IDLE;
      end
      WAIT_MEM: if (mem_hs) state_nxt = WRITE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready       = rst & (state == IDLE || state == WRITE);
    mem_rdata_ready = rst & (state == WAIT_MEM);
    accept          = req_valid & req_ready;
    mem_hs          = mem_rdata_valid & mem_rdata_ready;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_rd  <= req_rd;
      cap_op  <= req_ld_op;
      cap_off <= req_byte_off;
      cap_rt  <= req_rt_old;
    end
  end

  // ALU results go straight into the write registers; loads use the capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_done  <= 1'b0;
      wb_count <= '0;
    end else begin
      rf_wen   <= 1'b0;
      wb_done  <= 1'b0;
      wb_count <= wb_count + CNT_WIDTH'(rf_wen);
      if (accept && !req_is_load) begin
        rf_wen   <= req_rd != '0;
        rf_waddr <= req_rd;
        rf_wdata <= req_alu_result;
        wb_done  <= 1'b1;
      end else if (mem_hs) begin
        rf_wen   <= cap_rd != '0;
        rf_waddr <= cap_rd;
        rf_wdata <= ld_data;
        wb_done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized bench for reg_writeback against a transaction-level model.
// Load results come from shift/mask arithmetic on the raw word.
module tb_reg_writeback;

  localparam int LB  = 0;
  localparam int LH  = 1;
  localparam int LW  = 2;
  localparam int LBU = 4;
  localparam int LHU = 5;
  localparam int LWL = 6;
  localparam int LWR = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_load = 1'b0;
  logic [4:0]  req_rd = '0;
  logic [31:0] req_alu_result = '0;
  logic [2:0]  req_ld_op = '0;
  logic [1:0]  req_byte_off = '0;
  logic [31:0] req_rt_old = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rdata_valid = 1'b0;
  logic        mem_rdata_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_done;
  logic [31:0] wb_count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_cnt   = '0;

  logic [4:0]  brd[8];
  logic [31:0] bdat[8];

  reg_writeback dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_load     (req_is_load),
    .req_rd          (req_rd),
    .req_alu_result  (req_alu_result),
    .req_ld_op       (req_ld_op),
    .req_byte_off    (req_byte_off),
    .req_rt_old      (req_rt_old),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata_ready (mem_rdata_ready),
    .rf_wen          (rf_wen),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .wb_done         (wb_done),
    .wb_count        (wb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_align(input int op, input int off,
                                            input logic [31:0] rt,
                                            input logic [31:0] m);
    logic [63:0] keep;
    int v;
    case (op)
      LB, LBU: begin
        v = int'((m >> (8 * off)) & 32'hFF);
        if (op == LB && v > 127) v -= 256;
        return 32'(v);
      end
      LH, LHU: begin
        v = int'((m >> (16 * (off / 2))) & 32'hFFFF);
        if (op == LH && v > 32767) v -= 65536;
        return 32'(v);
      end
      LWL: begin
        keep = (64'd1 << (8 * (3 - off))) - 64'd1;
        return 32'((64'(m) << (8 * (3 - off))) | (64'(rt) & keep));
      end
      LWR: begin
        keep = (64'd1 << (32 - 8 * off)) - 64'd1;
        return (m >> (8 * off)) | (rt & ~keep[31:0]);
      end
      default: return m;
    endcase
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, ".wen"},   32'(rf_wen), 32'd0);
    chk({tag, ".done"},  32'(wb_done), 32'd0);
    chk({tag, ".waddr"}, 32'(rf_waddr), 32'(m_waddr));
    chk({tag, ".wdata"}, rf_wdata, m_wdata);
    chk({tag, ".cnt"},   wb_count, m_cnt);
  endtask

  task automatic check_write(input string tag, input logic [4:0] rd,
                             input logic [31:0] data);
    chk({tag, ".wen"},   32'(rf_wen), 32'(rd != 5'd0));
    chk({tag, ".done"},  32'(wb_done), 32'd1);
    chk({tag, ".waddr"}, 32'(rf_waddr), 32'(rd));
    chk({tag, ".wdata"}, rf_wdata, data);
    chk({tag, ".cnt"},   wb_count, m_cnt);
    m_waddr = rd;
    m_wdata = data;
    if (rd != 5'd0) m_cnt++;
  endtask

  task automatic alu_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) check_write("alu", brd[i-1], bdat[i-1]);
      req_valid       = 1'b1;
      req_is_load     = 1'b0;
      req_rd          = brd[i];
      req_alu_result  = bdat[i];
      req_ld_op       = 3'($urandom);
      req_byte_off    = 2'($urandom);
      mem_rdata_valid = 1'($urandom);
      mem_rdata       = $urandom;
      chk("alu.ready", 32'(req_ready), 32'd1);
    end
    @(negedge clk);
    req_valid       = 1'b0;
    mem_rdata_valid = 1'b0;
    check_write("alu", brd[n-1], bdat[n-1]);
    @(negedge clk);
    check_quiet("alu.end");
  endtask

  task automatic do_load(input logic [4:0] rd, input int op, input int off,
                         input logic [31:0] rt, input logic [31:0] m,
                         input int dly);
    @(negedge clk);
    req_valid       = 1'b1;
    req_is_load     = 1'b1;
    req_rd          = rd;
    req_ld_op       = 3'(op);
    req_byte_off    = 2'(off);
    req_rt_old      = rt;
    req_alu_result  = $urandom;
    mem_rdata_valid = 1'b0;
    chk("ld.ready", 32'(req_ready), 32'd1);
    chk("ld.mready0", 32'(mem_rdata_ready), 32'd0);
    @(negedge clk);
    req_valid    = 1'b0;
    req_rd       = 5'($urandom);
    req_rt_old   = $urandom;
    req_ld_op    = 3'($urandom);
    req_byte_off = 2'($urandom);
    check_quiet("ld.wait");
    for (int j = 0; j < dly; j++) begin
      chk("ld.mready", 32'(mem_rdata_ready), 32'd1);
      chk("ld.busy", 32'(req_ready), 32'd0);
      mem_rdata = $urandom;
      @(negedge clk);
    end
    chk("ld.mready", 32'(mem_rdata_ready), 32'd1);
    mem_rdata_valid = 1'b1;
    mem_rdata       = m;
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    mem_rdata       = $urandom;
    check_write("ld", rd, ref_align(op, off, rt, m));
    @(negedge clk);
    check_quiet("ld.end");
  endtask

  task automatic model_reset();
    m_waddr = '0;
    m_wdata = '0;
    m_cnt   = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.mready", 32'(mem_rdata_ready), 32'd0);
    check_quiet("rst");
    rst = 1'b1;
    @(negedge clk);
    chk("idle.ready", 32'(req_ready), 32'd1);

    brd[0] = 5'd5; bdat[0] = 32'h1234_5678;
    alu_burst(1);

    do_load(5'd7, LB, 3, $urandom, 32'h80FF_0000, 1);
    do_load(5'd8, LBU, 3, $urandom, 32'h80FF_0000, 1);
    do_load(5'd10, LWL, 1, 32'hAABB_CCDD, 32'h1122_3344, 0);
    do_load(5'd11, LWR, 2, 32'hAABB_CCDD, 32'h1122_3344, 0);

    for (int i = 0; i < 3; i++) begin
      brd[i] = 5'(i + 1); bdat[i] = $urandom;
    end
    alu_burst(3);

    brd[0] = 5'd0; bdat[0] = 32'hDEAD_BEEF;
    alu_burst(1);

    // reset while a load waits for memory
    @(negedge clk);
    req_valid = 1'b1; req_is_load = 1'b1; req_rd = 5'd12;
    req_ld_op = 3'(LW); req_byte_off = 2'd0;
    chk("rw.ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    model_reset();
    chk("rw.ready0", 32'(req_ready), 32'd0);
    chk("rw.mready0", 32'(mem_rdata_ready), 32'd0);
    check_quiet("rw.rst");
    rst = 1'b1; mem_rdata_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rw.ready1", 32'(req_ready), 32'd1);
    chk("rw.mready1", 32'(mem_rdata_ready), 32'd0);
    mem_rdata_valid = 1'b0;
    @(negedge clk);
    check_quiet("rw.after");

    // reset during the write cycle
    @(negedge clk);
    req_valid = 1'b1; req_is_load = 1'b0; req_rd = 5'd9;
    req_alu_result = 32'h0BAD_F00D;
    @(negedge clk);
    req_valid = 1'b0;
    check_write("rwr", 5'd9, 32'h0BAD_F00D);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    check_quiet("rwr.rst");
    rst = 1'b1;
    @(negedge clk);
    check_quiet("rwr.after");

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        n = int'($urandom_range(1, 6));
        for (int i = 0; i < n; i++) begin
          brd[i]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
          bdat[i] = $urandom;
        end
        alu_burst(n);
      end else begin
        do_load(5'($urandom), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)), $urandom, $urandom,
                int'($urandom_range(0, 3)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
